pc_sequencer: RTL and testbench

- Fetch-side controller that owns the program counter and sequences instruction fetch.
- Arbitrates next-PC sources: exception, branch, jump and sequential increment.
- Drives a req/ack handshake to instruction memory and squashes fetches made stale by a redirect.
- Sits between the decode/execute redirect logic and instruction memory; PC is word-addressed, sequential step is +1.

---
 rtl/pc_seq_pkg.sv | 28 ++
 rtl/pc_redirect_mux.sv | 30 +++
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and defaults for the fetch PC sequencer
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2,
    IDLE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EXC  = 2'd1,
    SRC_BR   = 2'd2,
    SRC_JMP  = 2'd3
  } redir_src_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0040;

  function automatic redir_src_e pick_src(input logic exc, input logic br_taken, input logic jmp);
    if (exc)           return SRC_EXC;
    else if (br_taken) return SRC_BR;
    else if (jmp)      return SRC_JMP;
    else               return SRC_NONE;
  endfunction

endpackage

// File: rtl/pc_redirect_mux.sv
// rtl/pc_redirect_mux.sv - priority select of the redirect target (exc > branch > jump)
module pc_redirect_mux
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
  input  logic              exc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_addr
);

  redir_src_e src;

  always_comb begin
    src            = pick_src(exc, br_taken, jmp);
    redirect_valid = (src != SRC_NONE);
    case (src)
      SRC_EXC: redirect_addr = EXC_VECTOR;
      SRC_BR:  redirect_addr = br_target;
      SRC_JMP: redirect_addr = jmp_target;
      default: redirect_addr = '0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and instruction fetch sequencer
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              exc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc
);

  state_e            state;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] fetch_next;
  logic [ADDR_W-1:0] squash_next;
  logic [ADDR_W-1:0] idle_next;

  pc_redirect_mux #(
    .ADDR_W     (ADDR_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_redirect_mux (
    .exc            (exc),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .jmp            (jmp),
    .jmp_target     (jmp_target),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr)
  );

  // A redirect arriving on the same edge as the ack is newer than anything pending.
  always_comb begin
    pc_inc      = pc + ADDR_W'(1);
    fetch_next  = redirect_valid ? redirect_addr : pc_inc;
    squash_next = redirect_valid ? redirect_addr : (pend_valid ? pend_addr : pc_inc);
    idle_next   = redirect_valid ? redirect_addr : pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      inst_valid <= 1'b0;
      inst_pc    <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      inst_valid <= 1'b0;
      case (state)
        BOOT, IDLE: begin
          pc        <= idle_next;
          imem_addr <= idle_next;
          imem_req  <= !stall;
          state     <= stall ? IDLE : REQ;
        end
        REQ: begin
          if (imem_ack) begin
            if (!redirect_valid) begin
              inst_valid <= 1'b1;
              inst_pc    <= pc;
            end
            pc        <= fetch_next;
            imem_addr <= fetch_next;
            imem_req  <= !stall;
            state     <= stall ? IDLE : REQ;
          end else if (redirect_valid) begin
            // Request stays on the bus unchanged; its data will be thrown away.
            pend_addr  <= redirect_addr;
            pend_valid <= 1'b1;
            state      <= SQUASH;
          end
        end
        SQUASH: begin
          if (imem_ack) begin
            pc         <= squash_next;
            imem_addr  <= squash_next;
            pend_valid <= 1'b0;
            imem_req   <= !stall;
            state      <= stall ? IDLE : REQ;
          end else if (redirect_valid) begin
            pend_addr <= redirect_addr;
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, exc, br_taken, jmp, imem_ack;
  logic [31:0] br_target, jmp_target;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, pc, inst_pc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .exc        (exc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .imem_ack   (imem_ack),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        ex;
    logic        br;
    logic [31:0] brt;
    logic        jp;
    logic [31:0] jt;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pcv;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic stl, input logic ex, input logic br,
                              input logic [31:0] brt, input logic jp, input logic [31:0] jt,
                              input logic ack, input logic req, input logic [31:0] addr,
                              input logic [31:0] pcv, input logic iv, input logic [31:0] ipc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.ex = ex; v.br = br; v.brt = brt; v.jp = jp; v.jt = jt;
    v.ack = ack; v.req = req; v.addr = addr; v.pcv = pcv; v.iv = iv; v.ipc = ipc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.stl; exc = v.ex; br_taken = v.br; br_target = v.brt;
    jmp = v.jp; jmp_target = v.jt; imem_ack = v.ack;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; exc = 1'b0; br_taken = 1'b0; jmp = 1'b0;
    imem_ack = 1'b0; br_target = '0; jmp_target = '0;

    //           rst stl ex br brt           jp jt            ack  req addr          pc            iv ipc
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,       0, 32'h0,        0,   0, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h1,        32'h1,        1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h2,        32'h2,        1, 32'h1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h3,        32'h3,        1, 32'h2));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h4,        32'h4,        1, 32'h3));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h5,        32'h5,        1, 32'h4));
    vecs.push_back(mk(0, 0, 0, 1, 32'h100,     0, 32'h0,        1,   1, 32'h100,      32'h100,      0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h101,      32'h101,      1, 32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       1, 32'h7,        1,   1, 32'h7,        32'h7,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       1, 32'h20,       0,   1, 32'h7,        32'h7,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        0,   1, 32'h7,        32'h7,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        0,   1, 32'h7,        32'h7,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h20,       32'h20,       0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h80,      1, 32'h90,       1,   1, 32'h40,       32'h40,       0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h80,      1, 32'h90,       1,   1, 32'h80,       32'h80,       0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h81,       32'h81,       1, 32'h80));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,        0,   1, 32'h81,       32'h81,       0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,        0,   1, 32'h81,       32'h81,       0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,        1,   0, 32'h0,        32'h82,       1, 32'h81));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,        0,   0, 32'h0,        32'h82,       0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        0,   1, 32'h82,       32'h82,       0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h83,       32'h83,       1, 32'h82));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,        1,   0, 32'h0,        32'h84,       1, 32'h83));
    vecs.push_back(mk(0, 1, 0, 1, 32'h0,       0, 32'h0,        0,   0, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        0,   1, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       1, 32'hFFFF_FFFF, 1,  1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h0,        32'h0,        1, 32'hFFFF_FFFF));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       1, 32'h30,       0,   1, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h50,      0, 32'h0,        0,   1, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,        1,   1, 32'h50,       32'h50,       0, 32'h0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      check($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(vecs[i].req));
      if (vecs[i].req || vecs[i].rst)
        check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("row%0d pc", i), pc, vecs[i].pcv);
      check($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].iv));
      if (vecs[i].iv || vecs[i].rst)
        check($sformatf("row%0d inst_pc", i), inst_pc, vecs[i].ipc);
    end

    // Reset while a squashed request is outstanding.
    reset = 1'b0; stall = 1'b0; exc = 1'b0; br_taken = 1'b0; imem_ack = 1'b0;
    jmp = 1'b1; jmp_target = 32'h70;
    step();
    check("squash pend_valid", 32'(dut.pend_valid), 32'd1);
    check("squash imem_req", 32'(imem_req), 32'd1);
    check("squash imem_addr", imem_addr, 32'h50);
    jmp = 1'b0;
    reset = 1'b1;
    step();
    check("rst pc", pc, 32'h0);
    check("rst imem_req", 32'(imem_req), 32'd0);
    check("rst imem_addr", imem_addr, 32'h0);
    check("rst pend_valid", 32'(dut.pend_valid), 32'd0);
    check("rst inst_valid", 32'(inst_valid), 32'd0);
    check("rst inst_pc", inst_pc, 32'h0);

    // Boot with stall held: no request until stall drops, then fetch starts at RESET_PC.
    reset = 1'b0; stall = 1'b1;
    step();
    check("boot stall imem_req", 32'(imem_req), 32'd0);
    step();
    check("idle stall imem_req", 32'(imem_req), 32'd0);
    stall = 1'b0;
    step();
    check("resume imem_req", 32'(imem_req), 32'd1);
    check("resume imem_addr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    step();
    check("resume inst_valid", 32'(inst_valid), 32'd1);
    check("resume inst_pc", inst_pc, 32'h0);
    check("resume next addr", imem_addr, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
